hazard_unit: RTL

//  Produces the stall and flush controls that steer the IF/ID, ID/EX and EX/MEM pipeline registers.
//  - Inputs: hazard state from ID/EX outputs (EX_MemRd, EX_WrReg, EX_RegWr) plus ID-stage operands.
//  - Outputs: drives the ID/EX bubble input (IDEX_Stall), PC/IF-ID hold and IF/ID flush.
//  - Also sequences multi-cycle data-memory waits with a timeout, and keeps saturating stall/flush counters.

---
 rtl/hazard_unit_pkg.sv | 19 +
 rtl/hazard_unit_sat_counter.sv | 22 ++
 rtl/hazard_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM encoding and
// the hardwired-zero register index.
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      LU_BUBBLE = 2'd1,
      MEM_WAIT  = 2'd2
   } hz_state_t;

   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic src_match(input logic       uses,
                                      input logic [4:0] src,
                                      input logic [4:0] dst);
      return uses && (src == dst);
   endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_count <= '0;
      else if (inc && (r_count != {CNT_W{1'b1}}))
         r_count <= r_count + CNT_W'(1);
   end

   assign count = r_count;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: same-cycle stall/flush/hold steering, memory
// wait sequencing with an abort timer, and stall/flush activity counters.
//
// state     | meaning
// RUN       | normal issue; all hazards evaluated
// LU_BUBBLE | one load-use bubble issued; load-use masked this cycle
// MEM_WAIT  | data memory busy; whole front end frozen until ack or timeout
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       ID_rs,
   input  logic [4:0]       ID_rt,
   input  logic             ID_UsesRs,
   input  logic             ID_UsesRt,
   input  logic             ID_Jump,
   input  logic             EX_MemRd,
   input  logic             EX_RegWr,
   input  logic [4:0]       EX_WrReg,
   input  logic             EX_BranchTaken,
   input  logic             MEM_MemReq,
   input  logic             MEM_MemAck,
   output logic             PC_Hold,
   output logic             IFID_Hold,
   output logic             IFID_Flush,
   output logic             IDEX_Stall,
   output logic             IDEX_Hold,
   output logic             EXMEM_Hold,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int TMR_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   hz_state_t        r_state, w_state_nxt;
   logic [TMR_W-1:0] r_timer, w_timer_nxt;
   logic             r_mem_timeout, w_set_timeout;
   logic             w_lu_hazard;
   logic             w_front_hold, w_back_hold, w_flush, w_stall;

   assign w_lu_hazard = EX_MemRd && EX_RegWr && (EX_WrReg != REG_ZERO) &&
                        (src_match(ID_UsesRs, ID_rs, EX_WrReg) ||
                         src_match(ID_UsesRt, ID_rt, EX_WrReg));

   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_set_timeout = 1'b0;
      w_front_hold  = 1'b0;
      w_back_hold   = 1'b0;
      w_flush       = 1'b0;
      w_stall       = 1'b0;
      case (r_state)
         RUN, LU_BUBBLE: begin
            w_state_nxt = RUN;
            if (MEM_MemReq && !MEM_MemAck) begin
               w_front_hold = 1'b1;
               w_back_hold  = 1'b1;
               w_state_nxt  = MEM_WAIT;
               w_timer_nxt  = TMR_W'(1);
            end else if (EX_BranchTaken) begin
               w_flush = 1'b1;
               w_stall = 1'b1;
            end else if (w_lu_hazard && (r_state == RUN)) begin
               w_front_hold = 1'b1;
               w_stall      = 1'b1;
               w_state_nxt  = LU_BUBBLE;
            end else if (ID_Jump) begin
               w_flush = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (MEM_MemAck) begin
               w_state_nxt = RUN;
               w_timer_nxt = '0;
            end else begin
               // holds stay up through the final counted cycle; RUN follows
               w_front_hold = 1'b1;
               w_back_hold  = 1'b1;
               if (r_timer == TMR_W'(MEM_TIMEOUT - 1)) begin
                  w_set_timeout = 1'b1;
                  w_state_nxt   = RUN;
                  w_timer_nxt   = '0;
               end else begin
                  w_timer_nxt = r_timer + TMR_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= RUN;
         r_timer       <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_timer <= w_timer_nxt;
         if (w_set_timeout)
            r_mem_timeout <= 1'b1;
      end
   end

   assign PC_Hold     = w_front_hold && !reset;
   assign IFID_Hold   = w_front_hold && !reset;
   assign IFID_Flush  = w_flush      && !reset;
   assign IDEX_Stall  = w_stall      && !reset;
   assign IDEX_Hold   = w_back_hold  && !reset;
   assign EXMEM_Hold  = w_back_hold  && !reset;
   assign mem_timeout = r_mem_timeout;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (PC_Hold),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (IFID_Flush),
      .count (flush_count)
   );

endmodule
